// File: rtl/dac_ctrl_pkg.sv
// Shared definitions for the chirp scheduler and the sine DAC core it drives.
package dac_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RAMP,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [1:0] DAC_RUN  = 2'b01;
  localparam logic [1:0] DAC_STOP = 2'b10;

endpackage

// File: rtl/dac_interval_timer.sv
// Loadable down-counter; expired_o is high once the loaded interval has elapsed.
module dac_interval_timer #(
  parameter int TIME_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [TIME_W-1:0] load_value_i,
  input  logic              en_i,
  output logic              expired_o
);

  logic [TIME_W-1:0] count_q;

  // A load of N gives exactly N cycles before expired_o is observed; N must be >= 1.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_value_i - TIME_W'(1);
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - TIME_W'(1);
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/dac_chirp_scheduler.sv
// Chirp burst sequencer: arms the DAC, ramps the step value, inserts gaps, repeats.
module dac_chirp_scheduler
  import dac_ctrl_pkg::*;
#(
  parameter int FREQ_W     = 8,
  parameter int TIME_W     = 16,
  parameter int COUNT_W    = 8,
  parameter int ARM_CYCLES = 64
) (
  input  logic               ipClk,
  input  logic               ipReset,
  input  logic               ipStart,
  input  logic               ipAbort,
  input  logic [FREQ_W-1:0]  ipStartFreq,
  input  logic [FREQ_W-1:0]  ipStopFreq,
  input  logic [FREQ_W-1:0]  ipStepFreq,
  input  logic [TIME_W-1:0]  ipDwell,
  input  logic [TIME_W-1:0]  ipGap,
  input  logic [COUNT_W-1:0] ipChirps,
  output logic [1:0]         opControl,
  output logic [FREQ_W-1:0]  opFreq,
  output logic               opBusy,
  output logic               opDone,
  output logic               opError,
  output logic [COUNT_W-1:0] opChirpIndex
);

  state_e             state_q, state_d;
  logic [FREQ_W-1:0]  start_q, start_d, stop_q, stop_d, step_q, step_d, cur_q, cur_d;
  logic [TIME_W-1:0]  dwell_q, dwell_d, gap_q, gap_d;
  logic [COUNT_W-1:0] chirps_q, chirps_d, idx_q, idx_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic               tmr_load, tmr_en, tmr_expired;
  logic [TIME_W-1:0]  tmr_value;
  logic [FREQ_W:0]    nxt;
  logic               last_chirp;

  dac_interval_timer #(.TIME_W(TIME_W)) u_timer (
    .clk_i       (ipClk),
    .rst_ni      (ipReset),
    .load_i      (tmr_load),
    .load_value_i(tmr_value),
    .en_i        (tmr_en),
    .expired_o   (tmr_expired)
  );

  // One extra bit so a sum past the top of the range ends the chirp instead of wrapping.
  assign nxt        = {1'b0, cur_q} + {1'b0, step_q};
  assign last_chirp = (chirps_q != '0) && (COUNT_W'(idx_q + COUNT_W'(1)) == chirps_q);

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    stop_d    = stop_q;
    step_d    = step_q;
    cur_d     = cur_q;
    dwell_d   = dwell_q;
    gap_d     = gap_q;
    chirps_d  = chirps_q;
    idx_d     = idx_q;
    ctrl_d    = ctrl_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_value = dwell_q;

    case (state_q)
      ST_IDLE: begin
        ctrl_d = DAC_STOP;
        busy_d = 1'b0;
        if (ipStart && !ipAbort) begin
          if ((ipStartFreq <= ipStopFreq) && (ipStepFreq != '0)) begin
            start_d   = ipStartFreq;
            stop_d    = ipStopFreq;
            step_d    = ipStepFreq;
            dwell_d   = (ipDwell == '0) ? TIME_W'(1) : ipDwell;
            gap_d     = ipGap;
            chirps_d  = ipChirps;
            cur_d     = ipStartFreq;
            idx_d     = '0;
            busy_d    = 1'b1;
            state_d   = ST_ARM;
            tmr_load  = 1'b1;
            tmr_value = TIME_W'(ARM_CYCLES);
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_ARM: begin
        tmr_en = 1'b1;
        if (tmr_expired) begin
          state_d  = ST_RAMP;
          ctrl_d   = DAC_RUN;
          tmr_load = 1'b1;
        end
      end
      ST_RAMP: begin
        tmr_en = 1'b1;
        if (tmr_expired) begin
          if (nxt <= {1'b0, stop_q}) begin
            cur_d    = nxt[FREQ_W-1:0];
            tmr_load = 1'b1;
          end else begin
            idx_d = COUNT_W'(idx_q + COUNT_W'(1));
            if (last_chirp) begin
              state_d = ST_DONE;
              ctrl_d  = DAC_STOP;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else if (gap_q == '0) begin
              cur_d    = start_q;
              tmr_load = 1'b1;
            end else begin
              cur_d     = start_q;
              state_d   = ST_GAP;
              ctrl_d    = DAC_STOP;
              tmr_load  = 1'b1;
              tmr_value = gap_q;
            end
          end
        end
      end
      ST_GAP: begin
        tmr_en = 1'b1;
        if (tmr_expired) begin
          state_d  = ST_RAMP;
          ctrl_d   = DAC_RUN;
          tmr_load = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ctrl_d  = DAC_STOP;
        busy_d  = 1'b0;
      end
    endcase

    if (ipAbort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      ctrl_d   = DAC_STOP;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      tmr_load = 1'b0;
    end
  end

  always_ff @(posedge ipClk) begin
    if (!ipReset) begin
      state_q  <= ST_IDLE;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      cur_q    <= '0;
      dwell_q  <= '0;
      gap_q    <= '0;
      chirps_q <= '0;
      idx_q    <= '0;
      ctrl_q   <= DAC_STOP;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      cur_q    <= cur_d;
      dwell_q  <= dwell_d;
      gap_q    <= gap_d;
      chirps_q <= chirps_d;
      idx_q    <= idx_d;
      ctrl_q   <= ctrl_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign opControl    = ctrl_q;
  assign opFreq       = cur_q;
  assign opBusy       = busy_q;
  assign opDone       = done_q;
  assign opError      = error_q;
  assign opChirpIndex = idx_q;

endmodule

// File: tb/tb_dac_chirp_scheduler.sv
// Directed bench for dac_chirp_scheduler with hand-computed chirp sequences.
module tb_dac_chirp_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start, abort;
  logic [7:0]  start_f, stop_f, step_f;
  logic [15:0] dwell, gap;
  logic [7:0]  chirps;
  logic [1:0]  ctrl;
  logic [7:0]  freq;
  logic        busy, done, err;
  logic [7:0]  idx;

  int total  = 0;
  int passed = 0;

  dac_chirp_scheduler dut (
    .ipClk       (clk),
    .ipReset     (rst_n),
    .ipStart     (start),
    .ipAbort     (abort),
    .ipStartFreq (start_f),
    .ipStopFreq  (stop_f),
    .ipStepFreq  (step_f),
    .ipDwell     (dwell),
    .ipGap       (gap),
    .ipChirps    (chirps),
    .opControl   (ctrl),
    .opFreq      (freq),
    .opBusy      (busy),
    .opDone      (done),
    .opError     (err),
    .opChirpIndex(idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic cfg(input int s, input int p, input int st, input int d, input int g, input int c);
    start_f = 8'(s);
    stop_f  = 8'(p);
    step_f  = 8'(st);
    dwell   = 16'(d);
    gap     = 16'(g);
    chirps  = 8'(c);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg(0, 0, 0, 0, 0, 0);
    step(3);
    chk("rst_ctrl", ctrl, 2); chk("rst_freq", freq, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_err", err, 0); chk("rst_idx", idx, 0);
    rst_n = 1'b1;
    step(1);

    // Basic single chirp 10..40 step 10, dwell 4
    cfg(10, 40, 10, 4, 0, 1);
    pulse_start();
    chk("basic_busy", busy, 1); chk("basic_arm_ctrl", ctrl, 2); chk("basic_arm_freq", freq, 10);
    step(63);
    chk("basic_arm_end_ctrl", ctrl, 2);
    step(1);
    chk("basic_run_ctrl", ctrl, 1);
    for (int k = 0; k < 16; k++) begin
      chk("basic_freq", freq, 10 + 10 * (k / 4));
      chk("basic_ctrl", ctrl, 1);
      step(1);
    end
    chk("basic_done", done, 1); chk("basic_busy_low", busy, 0);
    chk("basic_idx", idx, 1); chk("basic_end_ctrl", ctrl, 2);
    step(1);
    chk("basic_done_pulse", done, 0);
    $display("basic chirp 10..40 done");

    // Non-aligned stop 35: only 10,20,30
    cfg(10, 35, 10, 4, 0, 1);
    pulse_start();
    step(64);
    for (int k = 0; k < 12; k++) begin
      chk("nonalign_freq", freq, 10 + 10 * (k / 4));
      step(1);
    end
    chk("nonalign_done", done, 1);
    step(1);
    $display("non-aligned chirp 10..35 done");

    // Overflow: 250 + 10 exceeds 255 and must not wrap to 4
    cfg(250, 255, 10, 4, 0, 1);
    pulse_start();
    step(64);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_freq", freq, 250);
      step(1);
    end
    chk("ovf_done", done, 1);
    step(1);
    $display("overflow chirp 250..255 done");

    // Three chirps 10,20 dwell 2 with an 8-cycle gap
    cfg(10, 20, 10, 2, 8, 3);
    pulse_start();
    step(64);
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 4; k++) begin
        chk("multi_ramp_ctrl", ctrl, 1);
        chk("multi_ramp_freq", freq, 10 + 10 * (k / 2));
        step(1);
      end
      if (c < 2) begin
        for (int k = 0; k < 8; k++) begin
          chk("multi_gap_ctrl", ctrl, 2);
          chk("multi_gap_freq", freq, 10);
          chk("multi_gap_idx", idx, c + 1);
          chk("multi_gap_done", done, 0);
          step(1);
        end
      end
    end
    chk("multi_done", done, 1); chk("multi_idx", idx, 3);
    step(1);
    chk("multi_done_once", done, 0);
    $display("multi-chirp burst done");

    // Abort on the second step value
    cfg(10, 40, 10, 4, 0, 1);
    pulse_start();
    step(68);
    chk("abort_pre_freq", freq, 20);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_ctrl", ctrl, 2); chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    for (int k = 0; k < 20; k++) begin
      chk("abort_no_done", done, 0);
      step(1);
    end
    pulse_start();
    chk("restart_busy", busy, 1);
    step(64);
    chk("restart_ctrl", ctrl, 1);
    step(16);
    chk("restart_done", done, 1);
    step(1);
    $display("abort and restart done");

    // Invalid configurations
    cfg(10, 40, 0, 4, 0, 1);
    pulse_start();
    chk("inv_step_err", err, 1); chk("inv_step_busy", busy, 0); chk("inv_step_ctrl", ctrl, 2);
    step(1);
    chk("inv_step_err_pulse", err, 0);
    cfg(50, 20, 10, 4, 0, 1);
    pulse_start();
    chk("inv_order_err", err, 1); chk("inv_order_busy", busy, 0); chk("inv_order_ctrl", ctrl, 2);
    step(1);
    chk("inv_order_err_pulse", err, 0);
    $display("invalid config checks done");

    // Continuous back-to-back ramps, then reset mid-ramp
    cfg(10, 20, 10, 2, 0, 0);
    pulse_start();
    step(64);
    for (int k = 0; k < 12; k++) begin
      chk("cont_ctrl", ctrl, 1);
      chk("cont_freq", freq, 10 + 10 * ((k % 4) / 2));
      chk("cont_idx", idx, k / 4);
      step(1);
    end
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("mrst_ctrl", ctrl, 2); chk("mrst_freq", freq, 0); chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0); chk("mrst_err", err, 0); chk("mrst_idx", idx, 0);
    $display("continuous mode and reset done");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dac_chirp_scheduler.md
Name: dac_chirp_scheduler

Overview:
Sequencer that drives the sine DAC's control and frequency-step inputs to produce FMCW-style chirp bursts for the radar application. It ramps the sine step from a start value to a stop value in fixed increments, holding each value for a programmable dwell. Between chirps it parks the DAC in Stop for a programmable gap, and it repeats for N chirps or continuously. It sits between the host/config registers and the DAC core: opControl feeds the DAC's ipControl, and opFreq feeds its ipFreq.

Parameters:
FREQ_W, 8, width of frequency step values (matches DAC ipFreq)
TIME_W, 16, width of dwell/gap counters (ipClk cycles)
COUNT_W, 8, width of chirp count
ARM_CYCLES, 64, ipClk cycles DAC is held in Stop before each burst (must span ≥2 DAC SCK periods)

Ports:
ipClk  in  1  system clock
ipReset  in  1  synchronous, active-low reset
ipStart  in  1  one-cycle burst start request
ipAbort  in  1  one-cycle abort request
ipStartFreq  in  FREQ_W  first step value of each chirp
ipStopFreq  in  FREQ_W  upper bound of step value (inclusive)
ipStepFreq  in  FREQ_W  increment per dwell
ipDwell  in  TIME_W  cycles per step value (0 treated as 1)
ipGap  in  TIME_W  Stop cycles between chirps (0 = back-to-back)
ipChirps  in  COUNT_W  chirps per burst (0 = continuous until abort)
opControl  out  2  to DAC: 2'b01 run, 2'b10 stop
opFreq  out  FREQ_W  to DAC step input
opBusy  out  1  high from accepted start until IDLE
opDone  out  1  one-cycle pulse on normal burst completion
opError  out  1  one-cycle pulse on rejected start
opChirpIndex  out  COUNT_W  number of chirps completed in current burst

Behaviour:
- Reset (ipReset=0 at posedge): state IDLE, opControl=2'b10, opFreq=0, opBusy=0, opDone=0, opError=0, opChirpIndex=0, counters cleared. Reset mid-burst has the same effect.
- States: IDLE, ARM, RAMP, GAP, DONE.
- IDLE: opControl=2'b10. ipStart is accepted only when StartFreq<=StopFreq and StepFreq!=0. On accept: latch all ip config values, cur=StartFreq, opChirpIndex=0, opBusy=1, go to ARM.
- Invalid start: opError=1 for one cycle; remain IDLE.
- ARM: opControl=2'b10, opFreq=cur. After ARM_CYCLES cycles, go to RAMP. From accepted ipStart to opControl=2'b01 is exactly 1+ARM_CYCLES cycles.
- RAMP: opControl=2'b01, opFreq=cur; each value is held for max(Dwell,1) cycles. At dwell end, nxt=cur+Step is computed at FREQ_W+1 bits.
  - If nxt<=Stop: cur=nxt.
  - Otherwise the chirp ends and opChirpIndex increments.
- Overflow: a 9-bit sum above Stop ends the chirp; opFreq never wraps.
- At chirp end:
  - Chirps!=0 and index+1==Chirps: go to DONE.
  - Gap==0: stay in RAMP with cur=Start.
  - Otherwise: go to GAP.
- Continuous mode (Chirps=0): opChirpIndex wraps modulo 2^COUNT_W.
- GAP: opControl=2'b10, opFreq=Start for Gap cycles, then go to RAMP with cur=Start.
- DONE: opDone=1 for one cycle, opControl=2'b10, opBusy drops; next state IDLE.
- ipAbort in any non-IDLE state: next cycle IDLE, opControl=2'b10, opBusy=0, no opDone.
- ipAbort and ipStart in the same cycle: abort wins and start is ignored.
- ipStart while busy is ignored. Config inputs are sampled only on accept, so changes mid-burst have no effect.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package dac_ctrl_pkg:
  - state enum.
  - DAC control constants DAC_RUN=2'b01 and DAC_STOP=2'b10, to be shared with the DAC core.
- Sub-module dac_interval_timer: loadable TIME_W down-counter with load, enable and expired outputs, reused for the ARM, dwell and gap intervals.

Test Plan:
- Basic chirp (Start=10, Stop=40, Step=10, Dwell=4, Chirps=1, ARM_CYCLES=64): opControl=01 begins 65 cycles after start; opFreq is 10,20,30,40 for 4 cycles each; then opDone pulses, opBusy=0 and opChirpIndex=1.
- Non-aligned and overflow stop:
  - Start=10, Stop=35, Step=10 gives 10,20,30 only.
  - Start=250, Stop=255, Step=10 gives 250 only, with no wrap to 4.
- Multi-chirp with gap (Chirps=3, Gap=8): three ramps, each separated by 8 cycles of opControl=10 with opFreq=Start; opChirpIndex goes 1,2,3; opDone pulses once.
- Abort mid-RAMP on the 2nd step: next cycle opControl=10, opBusy=0, no opDone; a new ipStart is then accepted normally.
- Invalid config (Step=0, or Start=50 with Stop=20): opError pulses for one cycle, opBusy stays 0, opControl stays 10.
- Continuous mode plus reset (Chirps=0, Gap=0): back-to-back ramps with opControl held at 01; ipReset=0 mid-ramp returns every output to its reset value in the next cycle.
